// File: rtl/icb_ibuf_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : icb_ibuf_loader_pkg
// Brief    : Shared FSM encoding and ICB constants for the input-buffer loader.
// Revision : 1.0 - initial release
// ============================================================================
package icb_ibuf_loader_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_CMD   = 3'd2,
    ST_RSP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Word 0 of the input buffer in the default memory map
  localparam logic [31:0] c_default_base_addr = 32'h1004_2000;

  // ICB transfer size code for a full 32-bit word
  localparam logic [1:0] c_icb_size_word = 2'b10;

endpackage : icb_ibuf_loader_pkg
`default_nettype wire

// File: rtl/ibuf_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : ibuf_addr_gen
// Brief    : Word counter and write-address generator for the input buffer.
//            The counter is cleared on a new load and advanced after each
//            successful write; last_slot flags that the current word fills
//            the final buffer location.
// Revision : 1.0 - initial release
// ============================================================================
module ibuf_addr_gen
  import icb_ibuf_loader_pkg::*;
#(
  parameter int            AW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = AW'(c_default_base_addr),
  parameter int            NWORDS    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] addr,
  output logic          last_slot
);

  // Wide enough to hold NWORDS itself, so the compare below never aliases
  localparam int CW = $clog2(NWORDS + 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + CW'(1);

  // Word counter: clear on load request, step after each accepted write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= w_cnt_inc;
    end
  end

  // Byte address of the current word; the counter never passes NWORDS-1
  // while a command is presented, so no wrap is possible
  assign addr      = BASE_ADDR + AW'({r_cnt, 2'b00});
  assign last_slot = (w_cnt_inc == CW'(NWORDS));

endmodule : ibuf_addr_gen
`default_nettype wire

// File: rtl/icb_ibuf_loader.sv
`default_nettype none
// ============================================================================
// Module   : icb_ibuf_loader
// Brief    : Streams upstream words into an ICB-attached input buffer, one
//            write outstanding at a time, stopping on s_last, on a full
//            buffer, or on an ICB error response.
//            Build option: ICB_IBUF_LOADER_BYTESWAP_EN byte-reverses each
//            word on the write-data bus (timing unchanged).
// Revision : 1.0 - initial release
// ============================================================================
module icb_ibuf_loader
  import icb_ibuf_loader_pkg::*;
#(
  parameter int            AW        = 32,
  parameter int            DW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = AW'(c_default_base_addr),
  parameter int            NWORDS    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            err,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic            s_last,
  input  logic [DW-1:0]   s_data,
  output logic            o_icb_cmd_valid,
  input  logic            o_icb_cmd_ready,
  output logic            o_icb_cmd_read,
  output logic [AW-1:0]   o_icb_cmd_addr,
  output logic [DW-1:0]   o_icb_cmd_wdata,
  output logic [DW/8-1:0] o_icb_cmd_wmask,
  output logic [1:0]      o_icb_cmd_size,
  input  logic            o_icb_rsp_valid,
  output logic            o_icb_rsp_ready,
  input  logic            o_icb_rsp_err
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DW-1:0]   r_data;
  logic            r_last;
  logic            r_err;
  logic            w_cnt_clr;
  logic            w_cnt_inc;
  logic            w_last_slot;
  logic [DW-1:0]   w_wdata;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, counter control and handshake outputs
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_clr       = 1'b0;
    w_cnt_inc       = 1'b0;
    busy            = 1'b1;
    done            = 1'b0;
    s_ready         = 1'b0;
    o_icb_cmd_valid = 1'b0;
    o_icb_rsp_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        s_ready = 1'b1;
        if (s_valid) w_state_nxt = ST_CMD;
      end
      ST_CMD: begin
        o_icb_cmd_valid = 1'b1;
        if (o_icb_cmd_ready) w_state_nxt = ST_RSP;
      end
      ST_RSP: begin
        o_icb_rsp_ready = 1'b1;
        if (o_icb_rsp_valid) begin
          if (o_icb_rsp_err) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_cnt_inc   = 1'b1;
            w_state_nxt = (r_last || w_last_slot) ? ST_DONE : ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Holding registers keep the word stable while the command waits for ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_last <= 1'b0;
    end else if ((r_state == ST_FETCH) && s_valid) begin
      r_data <= s_data;
      r_last <= s_last;
    end
  end

  // Sticky error: set by an error response, cleared by the next accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_err <= 1'b0;
    end else if ((r_state == ST_RSP) && o_icb_rsp_valid && o_icb_rsp_err) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;

`ifdef ICB_IBUF_LOADER_BYTESWAP_EN
  // Byte-reverse the held word on its way to the bus
  for (genvar gi = 0; gi < DW/8; gi++) begin : g_byteswap
    assign w_wdata[8*gi +: 8] = r_data[DW-8-8*gi +: 8];
  end
`else
  assign w_wdata = r_data;
`endif

  ibuf_addr_gen #(
    .AW        (AW),
    .BASE_ADDR (BASE_ADDR),
    .NWORDS    (NWORDS)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (w_cnt_clr),
    .inc       (w_cnt_inc),
    .addr      (o_icb_cmd_addr),
    .last_slot (w_last_slot)
  );

  assign o_icb_cmd_read  = 1'b0;
  assign o_icb_cmd_wdata = w_wdata;
  assign o_icb_cmd_wmask = '1;
  assign o_icb_cmd_size  = c_icb_size_word;

endmodule : icb_ibuf_loader
`default_nettype wire

// File: tb/tb_icb_ibuf_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_icb_ibuf_loader
// Brief    : Self-checking bench for icb_ibuf_loader. A stream source and a
//            zero-latency ICB slave run in the background; each test pushes
//            the writes it expects and compares them with the observed ones.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icb_ibuf_loader;

  localparam int          AW     = 32;
  localparam int          DW     = 32;
  localparam int          NWORDS = 16;
  localparam logic [31:0] BASE   = 32'h1004_2000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rd;
    logic [3:0]  mask;
    logic [1:0]  size;
    int          cyc;
  } wr_t;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            busy;
  logic            done;
  logic            err;
  logic            s_valid;
  logic            s_ready;
  logic            s_last;
  logic [DW-1:0]   s_data;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_read;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_wmask;
  logic [1:0]      cmd_size;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_done   = 0;
  int n_writes = 0;
  int rsp_idx  = 0;
  int err_at   = -1;

  logic [32:0] src_q[$];
  logic [63:0] exp_q[$];
  wr_t         obs_q[$];

  icb_ibuf_loader #(
    .AW        (AW),
    .DW        (DW),
    .BASE_ADDR (BASE),
    .NWORDS    (NWORDS)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_last          (s_last),
    .s_data          (s_data),
    .o_icb_cmd_valid (cmd_valid),
    .o_icb_cmd_ready (cmd_ready),
    .o_icb_cmd_read  (cmd_read),
    .o_icb_cmd_addr  (cmd_addr),
    .o_icb_cmd_wdata (cmd_wdata),
    .o_icb_cmd_wmask (cmd_wmask),
    .o_icb_cmd_size  (cmd_size),
    .o_icb_rsp_valid (rsp_valid),
    .o_icb_rsp_ready (rsp_ready),
    .o_icb_rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected bus image of a stream word
  function automatic logic [31:0] exp_wdata(input logic [31:0] w);
`ifdef ICB_IBUF_LOADER_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Stream source: presents the head of src_q, pops on handshake
  initial begin
    logic        hs;
    logic [32:0] head;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    forever begin
      @(negedge clk);
      hs = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (hs && (src_q.size() > 0)) void'(src_q.pop_front());
      if (src_q.size() > 0) begin
        head    = src_q[0];
        s_valid = 1'b1;
        s_last  = head[32];
        s_data  = head[31:0];
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
      end
    end
  end

  // ICB slave + monitor: records writes, answers one cycle after each command
  initial begin
    logic hs_c;
    logic hs_r;
    wr_t  w;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      hs_c = cmd_valid && cmd_ready;
      hs_r = rsp_valid && rsp_ready;
      if (done) n_done++;
      if (hs_c) begin
        w.addr = cmd_addr;
        w.data = cmd_wdata;
        w.rd   = cmd_read;
        w.mask = cmd_wmask;
        w.size = cmd_size;
        w.cyc  = cyc;
        obs_q.push_back(w);
        n_writes++;
      end
      @(posedge clk);
      #1;
      if (hs_r) begin
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
      end
      if (hs_c) begin
        rsp_idx++;
        rsp_valid = 1'b1;
        rsp_err   = (rsp_idx == err_at);
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for a done pulse beyond count d0, bounded by limit cycles
  task automatic wait_done(input int d0, input int limit, output bit ok);
    int k = 0;
    while ((n_done == d0) && (k < limit)) begin
      @(posedge clk);
      k++;
    end
    ok = (n_done != d0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid got %b want 0", cmd_valid); end
    checks++; if (rsp_ready !== 1'b0) begin errors++; $display("FAIL reset_rsp_ready got %b want 0", rsp_ready); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_load();
    int  d0, w0, prev;
    bit  ok;
    wr_t o;
    logic [63:0] e;
    src_q.delete();
    exp_q.delete();
    for (int i = 1; i <= 16; i++) begin
      src_q.push_back({1'b0, 32'(i)});
      exp_q.push_back({BASE + 32'(4 * (i - 1)), exp_wdata(32'(i))});
    end
    d0 = n_done;
    w0 = n_writes;
    pulse_start();
    wait_done(d0, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_done_timeout got none want pulse"); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_after got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL full_done_width got %b want 0", done); end
    repeat (3) @(negedge clk);
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL full_done_count got %0d want 1", n_done - d0); end
    checks++; if (n_writes - w0 !== 16) begin errors++; $display("FAIL full_writes got %0d want 16", n_writes - w0); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL full_err got %b want 0", err); end
    prev = -1;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL full_extra_write got addr=%h want none", o.addr);
      end else begin
        e = exp_q.pop_front();
        if ({o.addr, o.data} !== e) begin
          errors++; $display("FAIL full_write got %h/%h want %h/%h", o.addr, o.data, e[63:32], e[31:0]);
        end
      end
      checks++;
      if ({o.rd, o.mask, o.size} !== {1'b0, 4'hF, 2'b10}) begin
        errors++; $display("FAIL full_cmd_fields got rd=%b mask=%h size=%b want 0/f/10", o.rd, o.mask, o.size);
      end
      if (prev >= 0) begin
        checks++;
        if (o.cyc - prev !== 3) begin errors++; $display("FAIL full_throughput got %0d want 3", o.cyc - prev); end
      end
      prev = o.cyc;
    end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL full_missing got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_last();
    int  d0, w0;
    bit  ok;
    wr_t o;
    logic [63:0] e;
    src_q.delete();
    exp_q.delete();
    for (int i = 1; i <= 5; i++) begin
      src_q.push_back({(i == 3), 32'hCAFE_0000 + 32'(i)});
      if (i <= 3) exp_q.push_back({BASE + 32'(4 * (i - 1)), exp_wdata(32'hCAFE_0000 + 32'(i))});
    end
    d0 = n_done;
    w0 = n_writes;
    pulse_start();
    wait_done(d0, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL last_done_timeout got none want pulse"); end
    repeat (4) @(negedge clk);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL last_s_ready got %b want 0", s_ready); end
    checks++; if (n_writes - w0 !== 3) begin errors++; $display("FAIL last_writes got %0d want 3", n_writes - w0); end
    checks++; if (src_q.size() !== 2) begin errors++; $display("FAIL last_unconsumed got %0d want 2", src_q.size()); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL last_extra_write got addr=%h want none", o.addr);
      end else begin
        e = exp_q.pop_front();
        if ({o.addr, o.data} !== e) begin
          errors++; $display("FAIL last_write got %h/%h want %h/%h", o.addr, o.data, e[63:32], e[31:0]);
        end
      end
    end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL last_missing got %0d want 0", exp_q.size()); end
  endtask

  // More words than buffer slots, plus a start pulse while busy
  task automatic test_overflow();
    int  d0, w0;
    bit  ok;
    wr_t o;
    logic [63:0] e;
    src_q.delete();
    exp_q.delete();
    for (int i = 0; i < 18; i++) begin
      src_q.push_back({1'b0, 32'h5A00_0000 + 32'(i)});
      if (i < NWORDS) exp_q.push_back({BASE + 32'(4 * i), exp_wdata(32'h5A00_0000 + 32'(i))});
    end
    d0 = n_done;
    w0 = n_writes;
    pulse_start();
    repeat (10) @(posedge clk);
    pulse_start();
    wait_done(d0, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_done_timeout got none want pulse"); end
    repeat (4) @(negedge clk);
    checks++; if (n_writes - w0 !== NWORDS) begin errors++; $display("FAIL ovf_writes got %0d want %0d", n_writes - w0, NWORDS); end
    checks++; if (src_q.size() !== 2) begin errors++; $display("FAIL ovf_unconsumed got %0d want 2", src_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_busy got %b want 0", busy); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL ovf_extra_write got addr=%h want none", o.addr);
      end else begin
        e = exp_q.pop_front();
        if ({o.addr, o.data} !== e) begin
          errors++; $display("FAIL ovf_write got %h/%h want %h/%h", o.addr, o.data, e[63:32], e[31:0]);
        end
      end
    end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL ovf_missing got %0d want 0", exp_q.size()); end
  endtask

  // Slave withholds ready; command must hold steady
  task automatic test_cmd_stall();
    int  d0, w0, k;
    bit  ok;
    logic [31:0] want_data;
    want_data = exp_wdata(32'h1122_3344);
    src_q.delete();
    exp_q.delete();
    src_q.push_back({1'b1, 32'h1122_3344});
    exp_q.push_back({BASE, want_data});
    @(posedge clk);
    #1 cmd_ready = 1'b0;
    d0 = n_done;
    w0 = n_writes;
    pulse_start();
    k = 0;
    @(negedge clk);
    while (!cmd_valid && (k < 20)) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({cmd_valid, cmd_addr, cmd_wdata} !== {1'b1, BASE, want_data}) begin
        errors++; $display("FAIL stall_hold cyc%0d got %b/%h/%h want 1/%h/%h", i, cmd_valid, cmd_addr, cmd_wdata, BASE, want_data);
      end
      if (i < 4) @(negedge clk);
    end
    @(posedge clk);
    #1 cmd_ready = 1'b1;
    wait_done(d0, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_done_timeout got none want pulse"); end
    repeat (2) @(negedge clk);
    checks++; if (n_writes - w0 !== 1) begin errors++; $display("FAIL stall_writes got %0d want 1", n_writes - w0); end
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL stall_write got %0d writes want 1", obs_q.size());
    end else if ({obs_q[0].addr, obs_q[0].data} !== exp_q[0]) begin
      errors++; $display("FAIL stall_write got %h/%h want %h/%h", obs_q[0].addr, obs_q[0].data, BASE, want_data);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_rsp_err();
    int  d0, w0;
    bit  ok;
    wr_t o;
    logic [63:0] e;
    src_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      src_q.push_back({1'b0, 32'hE000_0000 + 32'(i)});
      if (i < 2) exp_q.push_back({BASE + 32'(4 * i), exp_wdata(32'hE000_0000 + 32'(i))});
    end
    err_at = rsp_idx + 2;
    d0 = n_done;
    w0 = n_writes;
    pulse_start();
    wait_done(d0, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL err_done_timeout got none want pulse"); end
    repeat (3) @(negedge clk);
    err_at = -1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_flag got %b want 1", err); end
    checks++; if (n_writes - w0 !== 2) begin errors++; $display("FAIL err_writes got %0d want 2", n_writes - w0); end
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL err_done_count got %0d want 1", n_done - d0); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL err_extra_write got addr=%h want none", o.addr);
      end else begin
        e = exp_q.pop_front();
        if ({o.addr, o.data} !== e) begin
          errors++; $display("FAIL err_write got %h/%h want %h/%h", o.addr, o.data, e[63:32], e[31:0]);
        end
      end
    end
    src_q.delete();
    src_q.push_back({1'b1, 32'h0BAD_F00D});
    exp_q.push_back({BASE, exp_wdata(32'h0BAD_F00D)});
    d0 = n_done;
    pulse_start();
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL err_restart_busy got %b want 1", busy); end
    wait_done(d0, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL err_restart_timeout got none want pulse"); end
    repeat (2) @(negedge clk);
    checks++;
    if ((obs_q.size() != 1) || ({obs_q[0].addr, obs_q[0].data} !== exp_q[0])) begin
      errors++; $display("FAIL err_restart_write got %0d writes want 1 at %h", obs_q.size(), BASE);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // Asynchronous reset while a command is waiting for ready
  task automatic test_reset_mid();
    int k, w0;
    src_q.delete();
    exp_q.delete();
    src_q.push_back({1'b0, 32'h7777_0000});
    src_q.push_back({1'b1, 32'h7777_0001});
    @(posedge clk);
    #1 cmd_ready = 1'b0;
    w0 = n_writes;
    pulse_start();
    k = 0;
    @(negedge clk);
    while (!cmd_valid && (k < 20)) begin
      @(negedge clk);
      k++;
    end
    checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL rstmid_reach_cmd got %b want 1", cmd_valid); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rstmid_cmd_valid got %b want 0", cmd_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++; if ({s_ready, rsp_ready, done, err} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_outputs got %b want 0000", {s_ready, rsp_ready, done, err});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    cmd_ready = 1'b1;
    src_q.delete();
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle got %b want 0", busy); end
    checks++; if (n_writes - w0 !== 0) begin errors++; $display("FAIL rstmid_writes got %0d want 0", n_writes - w0); end
    obs_q.delete();
  endtask

  // Two loads with start right after done; second must restart at word 0
  task automatic test_back_to_back();
    int  d0, w0;
    bit  ok;
    wr_t o;
    logic [63:0] e;
    src_q.delete();
    exp_q.delete();
    src_q.push_back({1'b0, 32'hB2B0_0000});
    src_q.push_back({1'b1, 32'hB2B0_0001});
    src_q.push_back({1'b1, 32'hB2B0_0002});
    exp_q.push_back({BASE,        exp_wdata(32'hB2B0_0000)});
    exp_q.push_back({BASE + 32'd4, exp_wdata(32'hB2B0_0001)});
    exp_q.push_back({BASE,        exp_wdata(32'hB2B0_0002)});
    d0 = n_done;
    w0 = n_writes;
    pulse_start();
    wait_done(d0, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_first_timeout got none want pulse"); end
    pulse_start();
    wait_done(d0 + 1, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_second_timeout got none want pulse"); end
    repeat (3) @(negedge clk);
    checks++; if (n_done - d0 !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", n_done - d0); end
    checks++; if (n_writes - w0 !== 3) begin errors++; $display("FAIL b2b_writes got %0d want 3", n_writes - w0); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL b2b_extra_write got addr=%h want none", o.addr);
      end else begin
        e = exp_q.pop_front();
        if ({o.addr, o.data} !== e) begin
          errors++; $display("FAIL b2b_write got %h/%h want %h/%h", o.addr, o.data, e[63:32], e[31:0]);
        end
      end
    end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_missing got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    cmd_ready = 1'b1;
    test_reset();
    test_full_load();
    test_last();
    test_overflow();
    test_cmd_stall();
    test_rsp_err();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_icb_ibuf_loader
`default_nettype wire
